// File: rtl/rvmyth_dac_pkg.sv
// Shared types and default build constants for the rvmyth DAC serializer.
package rvmyth_dac_pkg;

    localparam int DEF_WIDTH    = 10;  // matches the core's OUT bus
    localparam int DEF_DEPTH    = 4;   // FIFO entries, power of two
    localparam int DEF_SCLK_DIV = 2;   // CLK cycles per SCLK half-period

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_END,
        ST_LDAC
    } dac_state_e;

endpackage

// File: rtl/rvmyth_dac_serializer_if.sv
// Sample input and DAC pin bundle between the core side and the serializer.
interface rvmyth_dac_serializer_if
    import rvmyth_dac_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
);
    logic [WIDTH-1:0]        OUT;
    logic                    SCLK;
    logic                    SDO;
    logic                    CS_N;
    logic                    LDAC_N;
    logic [$clog2(DEPTH):0]  level;
    logic                    busy;
    logic                    ovf;

    // Core side: drives samples, observes pins and status.
    modport master (output OUT,
                    input  SCLK, SDO, CS_N, LDAC_N, level, busy, ovf);

    // Serializer side.
    modport slave  (input  OUT,
                    output SCLK, SDO, CS_N, LDAC_N, level, busy, ovf);

endinterface

// File: rtl/rvmyth_sample_fifo.sv
// Circular sample buffer with occupancy counter; head is read combinationally.
module rvmyth_sample_fifo
    import rvmyth_dac_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic [LW-1:0]    level,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A push at full only lands when the head leaves in the same cycle.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign rd_data = mem[rd_ptr];

    // Storage array: written on accepted pushes, never reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/rvmyth_dac_serializer.sv
// Captures changes of the core's OUT bus and ships each one to a serial DAC
// as a CS_N-framed, MSB-first word followed by a one-cycle LDAC_N strobe.
module rvmyth_dac_serializer
    import rvmyth_dac_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int SCLK_DIV = DEF_SCLK_DIV
) (
    input  logic                   CLK,
    input  logic                   reset,
    rvmyth_dac_serializer_if.slave bus
);
    localparam int LW = $clog2(DEPTH) + 1;
    localparam int BW = $clog2(WIDTH);
    localparam int DW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCLK_DIV - 1);

    logic [WIDTH-1:0] in_q;
    logic [WIDTH-1:0] last_q;
    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] sr;
    logic [LW-1:0]    level;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    dac_state_e       state;
    logic [BW-1:0]    bit_cnt;
    logic [DW-1:0]    div_cnt;
    logic             sclk_q;
    logic             cs_n_q;
    logic             ldac_n_q;
    logic             busy_q;
    logic             ovf_q;

    // A sample is queued only when it differs from the last one queued.
    assign push = (in_q != last_q);
    assign pop  = (state == ST_IDLE) && !empty;

    // Input register plus change detector; last_q tracks even dropped samples.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            in_q   <= '0;
            last_q <= '0;
        end else begin
            in_q <= bus.OUT;
            if (push) last_q <= in_q;
        end
    end

    rvmyth_sample_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (CLK),
        .rst_n   (reset),
        .push    (push),
        .pop     (pop),
        .wr_data (in_q),
        .rd_data (head),
        .level   (level),
        .full    (full),
        .empty   (empty)
    );

    // Sticky overflow: a push that found the FIFO full with nothing leaving.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset)                    ovf_q <= 1'b0;
        else if (push && full && !pop) ovf_q <= 1'b1;
    end

    // Frame sequencer; every pin is set on the edge entering its state.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            sr       <= '0;
            bit_cnt  <= '0;
            div_cnt  <= '0;
            sclk_q   <= 1'b0;
            cs_n_q   <= 1'b1;
            ldac_n_q <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        sr     <= head;
                        cs_n_q <= 1'b0;
                        busy_q <= 1'b1;
                        state  <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    bit_cnt <= '0;
                    div_cnt <= '0;
                    state   <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (div_cnt != DIV_LAST) begin
                        div_cnt <= div_cnt + 1'b1;
                    end else begin
                        div_cnt <= '0;
                        if (!sclk_q) begin
                            sclk_q <= 1'b1;
                        end else if (bit_cnt == LAST_BIT) begin
                            sclk_q <= 1'b0;
                            cs_n_q <= 1'b1;
                            sr     <= '0;
                            state  <= ST_END;
                        end else begin
                            // Falling SCLK: next bit appears for the low phase.
                            sclk_q  <= 1'b0;
                            bit_cnt <= bit_cnt + 1'b1;
                            sr      <= {sr[WIDTH-2:0], 1'b0};
                        end
                    end
                end
                ST_END: begin
                    ldac_n_q <= 1'b0;
                    state    <= ST_LDAC;
                end
                ST_LDAC: begin
                    ldac_n_q <= 1'b1;
                    busy_q   <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.SCLK   = sclk_q;
    assign bus.SDO    = sr[WIDTH-1];
    assign bus.CS_N   = cs_n_q;
    assign bus.LDAC_N = ldac_n_q;
    assign bus.level  = level;
    assign bus.busy   = busy_q;
    assign bus.ovf    = ovf_q;

endmodule

// File: tb/tb_rvmyth_dac_serializer.sv
// Scoreboard bench: stimulus queues expected DAC words, a monitor decodes
// frames off the pins of two builds (SCLK_DIV=2 and SCLK_DIV=1).
module tb_rvmyth_dac_serializer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rvmyth_dac_serializer_if #(.WIDTH(10), .DEPTH(4)) bus0();
    rvmyth_dac_serializer_if #(.WIDTH(10), .DEPTH(4)) bus1();

    rvmyth_dac_serializer #(.WIDTH(10), .DEPTH(4), .SCLK_DIV(2)) u_dut0 (
        .CLK   (clk),
        .reset (rst_n),
        .bus   (bus0)
    );

    rvmyth_dac_serializer #(.WIDTH(10), .DEPTH(4), .SCLK_DIV(1)) u_dut1 (
        .CLK   (clk),
        .reset (rst_n),
        .bus   (bus1)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [9:0] exp_q[$];

    task automatic chk(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // ---------------- monitor ----------------
    wire [1:0] cs_n_v = {bus1.CS_N,   bus0.CS_N};
    wire [1:0] sclk_v = {bus1.SCLK,   bus0.SCLK};
    wire [1:0] sdo_v  = {bus1.SDO,    bus0.SDO};
    wire [1:0] ldac_v = {bus1.LDAC_N, bus0.LDAC_N};

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         in_fr[2], cs_cnt[2], nb[2], last_rise[2], ldac_due[2], frames[2];
    logic       prev_sclk[2], prev_sdo[2];
    logic [9:0] data[2];
    int         lvl_max = 0;
    int         starts[$];

    initial begin
        for (int d = 0; d < 2; d++) begin
            in_fr[d] = 0; ldac_due[d] = 0; frames[d] = 0;
            prev_sclk[d] = 1'b0; prev_sdo[d] = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst_n && int'(bus0.level) > lvl_max) lvl_max = int'(bus0.level);
        for (int d = 0; d < 2; d++) begin
            int dv;
            logic [9:0] e;
            dv = (d == 0) ? 2 : 1;
            if (!rst_n) begin
                in_fr[d] = 0; ldac_due[d] = 0; prev_sclk[d] = 1'b0;
            end else begin
                chk("ldac_n", ldac_v[d], (ldac_due[d] != 0) ? 0 : 1);
                ldac_due[d] = 0;
                if (!cs_n_v[d]) begin
                    if (in_fr[d] == 0) begin
                        in_fr[d] = 1; cs_cnt[d] = 0; nb[d] = 0;
                        data[d] = '0; last_rise[d] = -1;
                        if (d == 0) starts.push_back(cyc);
                    end
                    cs_cnt[d]++;
                    if (sclk_v[d] && !prev_sclk[d]) begin
                        data[d] = {data[d][8:0], sdo_v[d]};
                        nb[d]++;
                        if (last_rise[d] >= 0)
                            chk("sclk_period", cs_cnt[d] - last_rise[d], 2 * dv);
                        last_rise[d] = cs_cnt[d];
                    end else if (sclk_v[d] && prev_sclk[d]) begin
                        chk("sdo_hold", sdo_v[d], prev_sdo[d]);
                    end
                end else begin
                    chk("idle_sclk", sclk_v[d], 0);
                    chk("idle_sdo", sdo_v[d], 0);
                    if (in_fr[d] != 0) begin
                        in_fr[d] = 0; ldac_due[d] = 1; frames[d]++;
                        chk("cs_low_cycles", cs_cnt[d], 1 + 20 * dv);
                        chk("bit_count", nb[d], 10);
                        if (exp_q.size() == 0) begin
                            n_tests++; n_fail++;
                            $display("FAIL frame_unexpected: got %03h, expected no frame", data[d]);
                        end else begin
                            e = exp_q.pop_front();
                            chk("frame_data", data[d], e);
                        end
                    end
                end
                prev_sclk[d] = sclk_v[d];
                prev_sdo[d]  = sdo_v[d];
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; bus0.OUT = '0; bus1.OUT = '0; exp_q.delete();
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic wait_done(input int max_cyc);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus0.busy || bus1.busy ||
                in_fr[0] != 0 || in_fr[1] != 0) && n < max_cyc) begin
            tick();
            n++;
        end
        chk("drain_in_time", (n < max_cyc) ? 1 : 0, 1);
        repeat (4) tick();
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_cs_n"},   bus0.CS_N,   1);
        chk({tag, "_ldac_n"}, bus0.LDAC_N, 1);
        chk({tag, "_sclk"},   bus0.SCLK,   0);
        chk({tag, "_sdo"},    bus0.SDO,    0);
        chk({tag, "_level"},  bus0.level,  0);
        chk({tag, "_busy"},   bus0.busy,   0);
        chk({tag, "_ovf"},    bus0.ovf,    0);
    endtask

    initial begin
        int f0;
        int n;
        bus0.OUT = '0; bus1.OUT = '0;
        tick(); tick();
        chk_idle("in_reset");
        rst_n = 1'b1;

        // Constant zero input never starts a frame.
        for (int i = 0; i < 100; i++) begin
            tick();
            chk("hold_cs_n", bus0.CS_N, 1);
            chk("hold_busy", bus0.busy, 0);
        end
        chk_idle("hold_end");

        // Single sample 0x2A5: pins 3 edges after the step.
        f0 = frames[0];
        bus0.OUT = 10'h2A5; exp_q.push_back(10'h2A5);
        tick(); chk("e1_cs_n", bus0.CS_N, 1); chk("e1_level", bus0.level, 0);
        tick(); chk("e2_cs_n", bus0.CS_N, 1); chk("e2_level", bus0.level, 1);
        tick(); chk("e3_cs_n", bus0.CS_N, 0); chk("e3_level", bus0.level, 0);
        chk("e3_busy", bus0.busy, 1);
        wait_done(200);
        chk("single_frames", frames[0] - f0, 1);

        // Burst of four one-cycle samples.
        do_reset();
        lvl_max = 0; starts.delete();
        for (int v = 1; v <= 4; v++) begin
            bus0.OUT = 10'(v); exp_q.push_back(10'(v));
            tick();
        end
        wait_done(400);
        chk("burst_level_peak", lvl_max, 3);
        chk("burst_ovf", bus0.ovf, 0);
        chk("burst_frames", starts.size(), 4);
        for (int i = 1; i < starts.size(); i++)
            chk("burst_frame_spacing", starts[i] - starts[i-1], 44);

        // Overflow: seven changes back to back, last two dropped.
        do_reset();
        for (int v = 1; v <= 7; v++) begin
            bus0.OUT = 10'h100 + 10'(v);
            if (v <= 5) exp_q.push_back(10'h100 + 10'(v));
            tick();
        end
        tick(); tick();
        chk("ovf_set", bus0.ovf, 1);
        chk("ovf_level_full", bus0.level, 4);
        wait_done(500);
        chk("ovf_sticky", bus0.ovf, 1);

        // Reset mid-frame: ovf still set from above, must clear with reset.
        bus0.OUT = 10'h0F0; exp_q.push_back(10'h0F0);
        n = 0;
        while (bus0.CS_N && n < 10) begin tick(); n++; end
        chk("midrst_frame_started", bus0.CS_N, 0);
        repeat (21) @(posedge clk);
        #2;
        chk("midrst_busy_before", bus0.busy, 1);
        rst_n = 1'b0; exp_q.delete();
        #1;
        chk_idle("midrst_async");
        bus0.OUT = '0;
        tick(); tick(); tick();
        rst_n = 1'b1;
        tick(); tick();
        f0 = frames[0];
        bus0.OUT = 10'h3FF; exp_q.push_back(10'h3FF);
        tick(); tick(); tick();
        wait_done(200);
        chk("midrst_after_frames", frames[0] - f0, 1);

        // SCLK_DIV=1 build.
        f0 = frames[1];
        bus1.OUT = 10'h155; exp_q.push_back(10'h155);
        tick(); tick(); tick();
        chk("div1_cs_n_edge3", bus1.CS_N, 0);
        wait_done(100);
        chk("div1_frames", frames[1] - f0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

endmodule
